// File: rtl/mem_axi_bridge_if.sv
// AXI4-Lite data-port bundle between the MEM-stage bridge (master) and the memory system (slave).
// Signal suffixes are from the master's point of view.
interface mem_axi_bridge_if #(
  parameter int AXI_ADDR_BITS = 32,
  parameter int AXI_DATA_BITS = 32
);

  logic [AXI_ADDR_BITS-1:0]   m_awaddr_o;
  logic                       m_awvalid_o;
  logic                       m_awready_i;

  logic [AXI_DATA_BITS-1:0]   m_wdata_o;
  logic [AXI_DATA_BITS/8-1:0] m_wstrb_o;
  logic                       m_wvalid_o;
  logic                       m_wready_i;

  logic [1:0]                 m_bresp_i;
  logic                       m_bvalid_i;
  logic                       m_bready_o;

  logic [AXI_ADDR_BITS-1:0]   m_araddr_o;
  logic                       m_arvalid_o;
  logic                       m_arready_i;

  logic [AXI_DATA_BITS-1:0]   m_rdata_i;
  logic [1:0]                 m_rresp_i;
  logic                       m_rvalid_i;
  logic                       m_rready_o;

  modport master (
    output m_awaddr_o, m_awvalid_o,
    input  m_awready_i,
    output m_wdata_o, m_wstrb_o, m_wvalid_o,
    input  m_wready_i,
    input  m_bresp_i, m_bvalid_i,
    output m_bready_o,
    output m_araddr_o, m_arvalid_o,
    input  m_arready_i,
    input  m_rdata_i, m_rresp_i, m_rvalid_i,
    output m_rready_o
  );

  modport slave (
    input  m_awaddr_o, m_awvalid_o,
    output m_awready_i,
    input  m_wdata_o, m_wstrb_o, m_wvalid_o,
    output m_wready_i,
    output m_bresp_i, m_bvalid_i,
    input  m_bready_o,
    input  m_araddr_o, m_arvalid_o,
    output m_arready_i,
    output m_rdata_i, m_rresp_i, m_rvalid_i,
    input  m_rready_o
  );

endinterface

// File: rtl/mem_axi_bridge.sv
// Converts one MEM-stage load/store into a single AXI4-Lite transaction, stalling the pipeline until done.
// Optional macro MEM_AXI_RESP_CHECK_EN: report SLVERR/DECERR on resp_err_o and zero errored load data.
module mem_axi_bridge #(
  parameter int AXI_ADDR_BITS = 32,
  parameter int AXI_DATA_BITS = 32
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,

  input  logic                       req_valid_i,
  input  logic [31:0]                mem_addr_i,
  input  logic [31:0]                mem_write_data_i,
  input  logic                       mem_wen_i,
  input  logic [AXI_DATA_BITS/8-1:0] mem_wstrb_i,
  input  logic                       mem_ren_i,

  output logic [31:0]                mem_read_data_o,
  output logic                       stall_o,
  output logic                       resp_err_o,

  mem_axi_bridge_if.master           m_axi
);

  typedef enum logic [2:0] {
    IDLE,
    AR,
    R,
    WR,
    B,
    DONE
  } state_t;

  state_t                     r_state;
  logic [AXI_ADDR_BITS-1:0]   r_addr;
  logic [AXI_DATA_BITS-1:0]   r_wdata;
  logic [AXI_DATA_BITS/8-1:0] r_wstrb;
  logic                       r_awvalid;
  logic                       r_wvalid;
  logic                       r_bready;
  logic                       r_arvalid;
  logic                       r_rready;
  logic [31:0]                r_rdata;

  logic                       w_startReq;
  logic                       w_awDone;
  logic                       w_wDone;

  assign w_startReq = req_valid_i && (mem_wen_i || mem_ren_i);

  // A channel counts as done once its valid has dropped or it is handshaking this cycle.
  assign w_awDone = !r_awvalid || m_axi.m_awready_i;
  assign w_wDone  = !r_wvalid  || m_axi.m_wready_i;

  assign stall_o = ((r_state == IDLE) && w_startReq) ||
                   ((r_state != IDLE) && (r_state != DONE));

  assign m_axi.m_awaddr_o  = r_addr;
  assign m_axi.m_awvalid_o = r_awvalid;
  assign m_axi.m_wdata_o   = r_wdata;
  assign m_axi.m_wstrb_o   = r_wstrb;
  assign m_axi.m_wvalid_o  = r_wvalid;
  assign m_axi.m_bready_o  = r_bready;
  assign m_axi.m_araddr_o  = r_addr;
  assign m_axi.m_arvalid_o = r_arvalid;
  assign m_axi.m_rready_o  = r_rready;

  assign mem_read_data_o = r_rdata;

`ifdef MEM_AXI_RESP_CHECK_EN
  logic r_respErr;
  assign resp_err_o = r_respErr;
`else
  logic w_unusedResp;
  assign w_unusedResp = ^{m_axi.m_rresp_i, m_axi.m_bresp_i};
  assign resp_err_o   = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state   <= IDLE;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
      r_awvalid <= 1'b0;
      r_wvalid  <= 1'b0;
      r_bready  <= 1'b0;
      r_arvalid <= 1'b0;
      r_rready  <= 1'b0;
      r_rdata   <= '0;
`ifdef MEM_AXI_RESP_CHECK_EN
      r_respErr <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (w_startReq) begin
            r_addr  <= mem_addr_i[AXI_ADDR_BITS-1:0];
            r_wdata <= mem_write_data_i[AXI_DATA_BITS-1:0];
            r_wstrb <= mem_wstrb_i;
`ifdef MEM_AXI_RESP_CHECK_EN
            r_respErr <= 1'b0;
`endif
            // Stores win when both enables are set.
            if (mem_wen_i) begin
              r_awvalid <= 1'b1;
              r_wvalid  <= 1'b1;
              r_state   <= WR;
            end else begin
              r_arvalid <= 1'b1;
              r_state   <= AR;
            end
          end
        end

        AR: begin
          if (m_axi.m_arready_i) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
            r_state   <= R;
          end
        end

        R: begin
          if (m_axi.m_rvalid_i) begin
            r_rready <= 1'b0;
            r_state  <= DONE;
`ifdef MEM_AXI_RESP_CHECK_EN
            r_respErr <= m_axi.m_rresp_i[1];
            r_rdata   <= m_axi.m_rresp_i[1] ? 32'd0 : m_axi.m_rdata_i[31:0];
`else
            r_rdata   <= m_axi.m_rdata_i[31:0];
`endif
          end
        end

        WR: begin
          if (m_axi.m_awready_i) begin
            r_awvalid <= 1'b0;
          end
          if (m_axi.m_wready_i) begin
            r_wvalid <= 1'b0;
          end
          if (w_awDone && w_wDone) begin
            r_bready <= 1'b1;
            r_state  <= B;
          end
        end

        B: begin
          if (m_axi.m_bvalid_i) begin
            r_bready <= 1'b0;
            r_state  <= DONE;
`ifdef MEM_AXI_RESP_CHECK_EN
            r_respErr <= m_axi.m_bresp_i[1];
`endif
          end
        end

        DONE: begin
          r_state <= IDLE;
        end

        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_axi_bridge.sv
// Directed bench for mem_axi_bridge: a delay-configurable AXI4-Lite slave plus hand-computed expectations.
module tb_mem_axi_bridge;

  logic        clock;
  logic        resetN;
  logic        reqValid;
  logic [31:0] memAddr;
  logic [31:0] memWriteData;
  logic        memWen;
  logic [3:0]  memWstrb;
  logic        memRen;
  logic [31:0] memReadData;
  logic        stall;
  logic        respErr;

  mem_axi_bridge_if #(.AXI_ADDR_BITS(32), .AXI_DATA_BITS(32)) axi ();

  mem_axi_bridge #(.AXI_ADDR_BITS(32), .AXI_DATA_BITS(32)) dut (
    .clk_i            (clock),
    .rst_ni           (resetN),
    .req_valid_i      (reqValid),
    .mem_addr_i       (memAddr),
    .mem_write_data_i (memWriteData),
    .mem_wen_i        (memWen),
    .mem_wstrb_i      (memWstrb),
    .mem_ren_i        (memRen),
    .mem_read_data_o  (memReadData),
    .stall_o          (stall),
    .resp_err_o       (respErr),
    .m_axi            (axi)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int compareCount  = 0;
  int mismatchCount = 0;

  int arDelay = 0, rDelay = 0, awDelay = 0, wDelay = 0, bDelay = 0;
  logic [31:0] rdataCfg = '0;
  logic [1:0]  rrespCfg = 2'b00;
  logic [1:0]  brespCfg = 2'b00;

  int arCount = 0, rCount = 0, awCount = 0, wCount = 0, bCount = 0;
  int arViol = 0, awViol = 0, wViol = 0;
  logic [31:0] lastAraddr, lastAwaddr, lastWdata;
  logic [3:0]  lastWstrb;

  int arWait, rWait, awWait, wWait, bWait;
  bit rPending, bPending, awSeen, wSeen;
  bit arHeld, awHeld, wHeld;
  logic [31:0] heldAraddr, heldAwaddr, heldWdata;
  logic [3:0]  heldWstrb;

  int firstAr, firstR, firstB, arCyc, awCyc, wCyc;
  logic [31:0] doneData;
  logic        doneErr;

  // Handshake bookkeeping and valid/payload stability, sampled on the edge the DUT samples.
  always @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      rPending = 0; bPending = 0; awSeen = 0; wSeen = 0;
      arHeld = 0; awHeld = 0; wHeld = 0;
    end else begin
      if (arHeld && (!axi.m_arvalid_o || axi.m_araddr_o != heldAraddr)) arViol++;
      if (awHeld && (!axi.m_awvalid_o || axi.m_awaddr_o != heldAwaddr)) awViol++;
      if (wHeld && (!axi.m_wvalid_o || axi.m_wdata_o != heldWdata || axi.m_wstrb_o != heldWstrb)) wViol++;
      arHeld = axi.m_arvalid_o && !axi.m_arready_i; heldAraddr = axi.m_araddr_o;
      awHeld = axi.m_awvalid_o && !axi.m_awready_i; heldAwaddr = axi.m_awaddr_o;
      wHeld  = axi.m_wvalid_o && !axi.m_wready_i;
      heldWdata = axi.m_wdata_o; heldWstrb = axi.m_wstrb_o;

      if (axi.m_arvalid_o && axi.m_arready_i) begin arCount++; lastAraddr = axi.m_araddr_o; rPending = 1; end
      if (axi.m_rvalid_i && axi.m_rready_o) begin rCount++; rPending = 0; end
      if (axi.m_awvalid_o && axi.m_awready_i) begin awCount++; lastAwaddr = axi.m_awaddr_o; awSeen = 1; end
      if (axi.m_wvalid_o && axi.m_wready_i) begin
        wCount++; lastWdata = axi.m_wdata_o; lastWstrb = axi.m_wstrb_o; wSeen = 1;
      end
      if (axi.m_bvalid_i && axi.m_bready_o) begin bCount++; bPending = 0; end
      if (awSeen && wSeen) begin bPending = 1; awSeen = 0; wSeen = 0; end
    end
  end

  // Slave responses change on the falling edge, after holding off for the configured number of cycles.
  always @(negedge clock or negedge resetN) begin
    if (!resetN) begin
      axi.m_arready_i = 0; axi.m_awready_i = 0; axi.m_wready_i = 0;
      axi.m_rvalid_i = 0; axi.m_rdata_i = '0; axi.m_rresp_i = 2'b00;
      axi.m_bvalid_i = 0; axi.m_bresp_i = 2'b00;
      arWait = 0; rWait = 0; awWait = 0; wWait = 0; bWait = 0;
    end else begin
      if (axi.m_arvalid_o) begin
        if (arWait >= arDelay) axi.m_arready_i = 1; else begin axi.m_arready_i = 0; arWait++; end
      end else begin axi.m_arready_i = 0; arWait = 0; end
      if (axi.m_awvalid_o) begin
        if (awWait >= awDelay) axi.m_awready_i = 1; else begin axi.m_awready_i = 0; awWait++; end
      end else begin axi.m_awready_i = 0; awWait = 0; end
      if (axi.m_wvalid_o) begin
        if (wWait >= wDelay) axi.m_wready_i = 1; else begin axi.m_wready_i = 0; wWait++; end
      end else begin axi.m_wready_i = 0; wWait = 0; end
      if (rPending) begin
        if (rWait >= rDelay) begin
          axi.m_rvalid_i = 1; axi.m_rdata_i = rdataCfg; axi.m_rresp_i = rrespCfg;
        end else begin axi.m_rvalid_i = 0; rWait++; end
      end else begin axi.m_rvalid_i = 0; rWait = 0; end
      if (bPending) begin
        if (bWait >= bDelay) begin axi.m_bvalid_i = 1; axi.m_bresp_i = brespCfg; end
        else begin axi.m_bvalid_i = 0; bWait++; end
      end else begin axi.m_bvalid_i = 0; bWait = 0; end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compareCount++;
    if (observed !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Presents one request, holds it while stalled and drops it in the DONE cycle; cycle 0 is the request cycle.
  task automatic applyStimulus(input logic isWrite, input logic [31:0] addr, input logic [31:0] data,
                               input logic [3:0] strb, output int stallCycles);
    bit finished;
    finished = 0; stallCycles = 0;
    firstAr = -1; firstR = -1; firstB = -1; arCyc = 0; awCyc = 0; wCyc = 0;
    @(posedge clock); #1;
    reqValid = 1; memWen = isWrite; memRen = ~isWrite;
    memAddr = addr; memWriteData = data; memWstrb = strb;
    for (int c = 0; c < 64 && !finished; c++) begin
      #1;
      if (axi.m_arvalid_o) begin arCyc++; if (firstAr < 0) firstAr = c; end
      if (axi.m_rready_o && firstR < 0) firstR = c;
      if (axi.m_bready_o && firstB < 0) firstB = c;
      if (axi.m_awvalid_o) awCyc++;
      if (axi.m_wvalid_o) wCyc++;
      if (!stall) begin
        finished = 1; doneData = memReadData; doneErr = respErr;
        reqValid = 0; memWen = 0; memRen = 0;
      end else begin
        stallCycles++;
        @(posedge clock); #1;
      end
    end
    checkOutput("txnFinished", 32'(finished), 32'd1);
    reqValid = 0; memWen = 0; memRen = 0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int st, arBase, awBase, wBase, rBase, bBase;
    bit seenR;

    resetN = 0; reqValid = 0; memWen = 0; memRen = 0;
    memAddr = '0; memWriteData = '0; memWstrb = '0;
    #12;
    checkOutput("rstValids", {27'd0, axi.m_arvalid_o, axi.m_awvalid_o, axi.m_wvalid_o,
                              axi.m_rready_o, axi.m_bready_o}, 32'd0);
    checkOutput("rstAddr", axi.m_araddr_o | axi.m_awaddr_o, 32'd0);
    checkOutput("rstWdata", axi.m_wdata_o, 32'd0);
    checkOutput("rstWstrb", 32'(axi.m_wstrb_o), 32'd0);
    checkOutput("rstReadData", memReadData, 32'd0);
    checkOutput("rstRespErr", 32'(respErr), 32'd0);
    checkOutput("rstStall", 32'(stall), 32'd0);
    @(posedge clock); #3 resetN = 1;

    // Minimum-latency read.
    arBase = arCount; rdataCfg = 32'hDEAD_BEEF;
    applyStimulus(1'b0, 32'h0000_1000, 32'h0, 4'h0, st);
    checkOutput("rdStall", 32'(st), 32'd3);
    checkOutput("rdFirstAr", 32'(firstAr), 32'd1);
    checkOutput("rdFirstR", 32'(firstR), 32'd2);
    checkOutput("rdData", doneData, 32'hDEAD_BEEF);
    checkOutput("rdAraddr", lastAraddr, 32'h0000_1000);
    checkOutput("rdArCount", 32'(arCount - arBase), 32'd1);
    checkOutput("rdErr", 32'(doneErr), 32'd0);

    // Write with W accepted two cycles ahead of AW.
    awBase = awCount; wBase = wCount; bBase = bCount; awDelay = 2; wDelay = 0;
    applyStimulus(1'b1, 32'h0000_0010, 32'h1234_5678, 4'b0011, st);
    checkOutput("wrStall", 32'(st), 32'd5);
    checkOutput("wrWvalidCycles", 32'(wCyc), 32'd1);
    checkOutput("wrAwvalidCycles", 32'(awCyc), 32'd3);
    checkOutput("wrFirstB", 32'(firstB), 32'd4);
    checkOutput("wrAwCount", 32'(awCount - awBase), 32'd1);
    checkOutput("wrWCount", 32'(wCount - wBase), 32'd1);
    checkOutput("wrBCount", 32'(bCount - bBase), 32'd1);
    checkOutput("wrAwaddr", lastAwaddr, 32'h0000_0010);
    checkOutput("wrWdata", lastWdata, 32'h1234_5678);
    checkOutput("wrWstrb", 32'(lastWstrb), 32'h3);
    checkOutput("wrKeepsReadData", doneData, 32'hDEAD_BEEF);
    awDelay = 0;

    // AR backpressure of three cycles.
    arBase = arCount; arDelay = 3; rdataCfg = 32'h0BAD_F00D;
    applyStimulus(1'b0, 32'h0000_2000, 32'h0, 4'h0, st);
    checkOutput("arBpStall", 32'(st), 32'd6);
    checkOutput("arBpArvalidCycles", 32'(arCyc), 32'd4);
    checkOutput("arBpArCount", 32'(arCount - arBase), 32'd1);
    checkOutput("arBpAraddr", lastAraddr, 32'h0000_2000);
    checkOutput("arBpData", doneData, 32'h0BAD_F00D);
    arDelay = 0;

    // Store immediately followed by a load.
    arBase = arCount; awBase = awCount; wBase = wCount;
    applyStimulus(1'b1, 32'h0000_0020, 32'hAAAA_5555, 4'hF, st);
    checkOutput("b2bStoreStall", 32'(st), 32'd3);
    checkOutput("b2bStoreKeepsData", doneData, 32'h0BAD_F00D);
    rdataCfg = 32'h1357_9BDF;
    applyStimulus(1'b0, 32'h0000_0024, 32'h0, 4'h0, st);
    checkOutput("b2bLoadData", doneData, 32'h1357_9BDF);
    checkOutput("b2bArCount", 32'(arCount - arBase), 32'd1);
    checkOutput("b2bAwCount", 32'(awCount - awBase), 32'd1);
    checkOutput("b2bWCount", 32'(wCount - wBase), 32'd1);
    checkOutput("b2bAraddr", lastAraddr, 32'h0000_0024);
    checkOutput("b2bAwaddr", lastAwaddr, 32'h0000_0020);

    // Reset while waiting in R.
    rBase = rCount; rDelay = 10; rdataCfg = 32'h7777_7777;
    @(posedge clock); #1;
    reqValid = 1; memRen = 1; memAddr = 32'h0000_3000;
    seenR = 0;
    for (int c = 0; c < 20 && !seenR; c++) begin
      @(posedge clock); #2;
      seenR = axi.m_rready_o;
    end
    checkOutput("rstMidReachedR", 32'(seenR), 32'd1);
    #1 resetN = 0;
    #1;
    checkOutput("rstMidValids", {27'd0, axi.m_arvalid_o, axi.m_awvalid_o, axi.m_wvalid_o,
                                 axi.m_rready_o, axi.m_bready_o}, 32'd0);
    checkOutput("rstMidReadData", memReadData, 32'd0);
    checkOutput("rstMidStallReq", 32'(stall), 32'd1);
    reqValid = 0; memRen = 0;
    #1;
    checkOutput("rstMidStallIdle", 32'(stall), 32'd0);
    @(posedge clock); @(posedge clock); #3 resetN = 1;
    checkOutput("rstMidNoCompletion", 32'(rCount - rBase), 32'd0);
    rDelay = 0; rdataCfg = 32'h600D_CAFE;
    applyStimulus(1'b0, 32'h0000_3004, 32'h0, 4'h0, st);
    checkOutput("postRstStall", 32'(st), 32'd3);
    checkOutput("postRstData", doneData, 32'h600D_CAFE);

    // Error responses.
    rdataCfg = 32'hCAFE_F00D; rrespCfg = 2'b10;
    applyStimulus(1'b0, 32'h0000_4000, 32'h0, 4'h0, st);
`ifdef MEM_AXI_RESP_CHECK_EN
    checkOutput("rdErrFlag", 32'(doneErr), 32'd1);
    checkOutput("rdErrData", doneData, 32'd0);
`else
    checkOutput("rdErrFlag", 32'(doneErr), 32'd0);
    checkOutput("rdErrData", doneData, 32'hCAFE_F00D);
`endif
    rrespCfg = 2'b00; brespCfg = 2'b11;
    applyStimulus(1'b1, 32'h0000_4004, 32'h0102_0304, 4'hF, st);
`ifdef MEM_AXI_RESP_CHECK_EN
    checkOutput("wrErrFlag", 32'(doneErr), 32'd1);
    checkOutput("wrErrKeepsData", doneData, 32'd0);
`else
    checkOutput("wrErrFlag", 32'(doneErr), 32'd0);
    checkOutput("wrErrKeepsData", doneData, 32'hCAFE_F00D);
`endif
    brespCfg = 2'b00;
    applyStimulus(1'b0, 32'h0000_4008, 32'h0, 4'h0, st);
    checkOutput("errClearedFlag", 32'(doneErr), 32'd0);
    checkOutput("errClearedData", doneData, 32'hCAFE_F00D);

    repeat (2) @(posedge clock);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
